// File: rtl/logic_array_pkg.sv
// Opcodes, sizing constants and the per-channel gate function shared by the logic array.
// Gate evaluation is purely combinational; the caller owns the result register.
package logic_array_pkg;

   localparam int OP_W         = 3;
   localparam int MAX_CHANNELS = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND    = 3'd0,
      OP_OR     = 3'd1,
      OP_XOR    = 3'd2,
      OP_NAND   = 3'd3,
      OP_NOR    = 3'd4,
      OP_XNOR   = 3'd5,
      OP_PASS   = 3'd6,
      OP_TOGGLE = 3'd7
   } op_t;

   // The counter only ever holds 0..depth-1 because it clears on the update cycle.
   function automatic int filter_cnt_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic logic gate_eval(input op_t op, input logic a, input logic b,
                                      input logic cur, input logic a_prev);
      logic r;
      case (op)
         OP_AND:    r = a & b;
         OP_OR:     r = a | b;
         OP_XOR:    r = a ^ b;
         OP_NAND:   r = ~(a & b);
         OP_NOR:    r = ~(a | b);
         OP_XNOR:   r = ~(a ^ b);
         OP_PASS:   r = a;
         OP_TOGGLE: r = cur ^ (a & ~a_prev & b);
         default:   r = cur;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_array_if.sv
// Tiny Tapeout style pin bundle for the logic array; the DUT takes the slave view.
interface logic_array_if;

   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;

   modport master (output ui_in, output uio_in, output ena,
                   input  uo_out, input uio_out, input uio_oe);

   modport slave  (input  ui_in, input uio_in, input ena,
                   output uo_out, output uio_out, output uio_oe);

endinterface

// File: rtl/la_input_filter.sv
// One-bit 2-flop synchroniser followed by a stability filter; output lags input by 2+FILTER_DEPTH cycles.
// FILTER_DEPTH = 0 leaves only the synchroniser; no backpressure.
module la_input_filter
   import logic_array_pkg::*;
#(
   parameter int FILTER_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean
);

   logic [1:0] sync_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[0], raw};
      end
   end

   generate
      if (FILTER_DEPTH == 0) begin : g_bypass
         assign clean = sync_ff[1];
      end else begin : g_filter
         localparam int CW = filter_cnt_width(FILTER_DEPTH);

         logic [CW-1:0] cnt;
         logic          filt;

         // Update on the cycle that completes FILTER_DEPTH consecutive differing samples.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt  <= '0;
               filt <= 1'b0;
            end else if (sync_ff[1] == filt) begin
               cnt <= '0;
            end else if (cnt == CW'(FILTER_DEPTH - 1)) begin
               filt <= sync_ff[1];
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         assign clean = filt;
      end
   endgenerate

endmodule

// File: rtl/tt_um_logic_array.sv
// Multi-channel runtime-configurable gate array with serial config load and MSB readback.
// Operand to result: 3+FILTER_DEPTH edges; change pulse coincides with the result update; no backpressure.
module tt_um_logic_array
   import logic_array_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int FILTER_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   logic_array_if.slave bus
);

   localparam int W = OP_W * CHANNELS;

   logic [CHANNELS-1:0] opnd_a;
   logic [CHANNELS-1:0] opnd_b;
   logic [2:0]          cfg_sync;
   logic [2:1]          strobe_prev;
   logic                shift_pulse;
   logic                latch_pulse;

   logic [W-1:0]        shift_reg;
   logic [W-1:0]        active_cfg;

   logic [CHANNELS-1:0] result;
   logic [CHANNELS-1:0] result_next;
   logic [CHANNELS-1:0] change;
   logic [CHANNELS-1:0] a_prev;
   logic [7:0]          uo_word;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_chan
         la_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_a (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.ui_in[2*g]),
            .clean (opnd_a[g])
         );
         la_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_b (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.ui_in[2*g+1]),
            .clean (opnd_b[g])
         );
      end

      // Config pins only need metastability protection; edge detection does the rest.
      for (g = 0; g < 3; g++) begin : g_cfg
         la_input_filter #(.FILTER_DEPTH(0)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.uio_in[g]),
            .clean (cfg_sync[g])
         );
      end
   endgenerate

   assign shift_pulse = cfg_sync[1] & ~strobe_prev[1];
   assign latch_pulse = cfg_sync[2] & ~strobe_prev[2];

   always_comb begin
      result_next = result;
      for (int n = 0; n < CHANNELS; n++) begin
         result_next[n] = gate_eval(op_t'(active_cfg[OP_W*n +: OP_W]),
                                    opnd_a[n], opnd_b[n], result[n], a_prev[n]);
      end
   end

   // A simultaneous latch sees shift_reg before this edge's shift lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_prev <= '0;
         shift_reg   <= '0;
         active_cfg  <= '0;
         result      <= '0;
         change      <= '0;
         a_prev      <= '0;
      end else begin
         strobe_prev <= cfg_sync[2:1];
         if (shift_pulse) begin
            shift_reg <= {shift_reg[W-2:0], cfg_sync[0]};
         end
         if (latch_pulse) begin
            active_cfg <= shift_reg;
         end
         result <= result_next;
         change <= result ^ result_next;
         a_prev <= opnd_a;
      end
   end

   always_comb begin
      uo_word                = '0;
      uo_word[CHANNELS-1:0]  = result;
      uo_word[4 +: CHANNELS] = change;
   end

   assign bus.uo_out  = uo_word;
   assign bus.uio_out = {shift_reg[W-1], 7'b000_0000};
   assign bus.uio_oe  = 8'b1000_0000;

   logic unused;
   assign unused = &{1'b0, bus.ena, bus.uio_in[7:3], bus.ui_in};

endmodule

// File: tb/tb_tt_um_logic_array.sv
// Scoreboard bench: stimulus queues expected change events and steady-state samples, a negedge monitor compares.
`timescale 1ns/1ps
module tb_tt_um_logic_array;
   import logic_array_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic_array_if bus ();
   logic_array_if bus1 ();

   assign bus1.ui_in  = bus.ui_in;
   assign bus1.uio_in = bus.uio_in;
   assign bus1.ena    = bus.ena;

   tt_um_logic_array #(.CHANNELS(4), .FILTER_DEPTH(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   tt_um_logic_array #(.CHANNELS(1), .FILTER_DEPTH(2)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int         n_vec = 0;
   int         n_bad = 0;
   logic       finish_req = 1'b0;
   logic       mon_done = 1'b0;

   logic [7:0] ev_q[$];
   int         kind_q[$];
   string      name_q[$];
   logic [7:0] val_q[$];

   logic [7:0]  m_ui;
   logic [11:0] m_sr;
   logic [11:0] m_act;
   logic [3:0]  m_res;

   // kind: 0 uo_out, 1 uio_out, 2 uio_oe, 3 single-channel uo_out, 4 single-channel absent bits
   always @(negedge clk) begin
      logic [7:0] exp_v;
      logic [7:0] act_v;
      int         k;
      string      nm;
      if (bus.uo_out[7:4] != 4'h0) begin
         n_vec++;
         if (ev_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse got=%02h want=no_pulse", bus.uo_out);
         end else begin
            exp_v = ev_q.pop_front();
            if (bus.uo_out !== exp_v) begin
               n_bad++;
               $display("FAIL change_event got=%02h want=%02h", bus.uo_out, exp_v);
            end
         end
      end
      while (kind_q.size() > 0) begin
         k     = kind_q.pop_front();
         nm    = name_q.pop_front();
         exp_v = val_q.pop_front();
         case (k)
            0:       act_v = bus.uo_out;
            1:       act_v = bus.uio_out;
            2:       act_v = bus.uio_oe;
            3:       act_v = bus1.uo_out;
            default: act_v = bus1.uo_out & 8'hEE;
         endcase
         n_vec++;
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s got=%02h want=%02h", nm, act_v, exp_v);
         end
      end
      if (finish_req && !mon_done) begin
         n_vec++;
         if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_pulses got=0 want=%0d", ev_q.size());
         end
         mon_done = 1'b1;
      end
   end

   function automatic logic [3:0] model_res(input logic [11:0] act, input logic [7:0] ui_new,
                                            input logic [7:0] ui_old, input logic [3:0] res_old);
      logic [3:0] r;
      logic       a, b, ao;
      r = res_old;
      for (int n = 0; n < 4; n++) begin
         a  = ui_new[2*n];
         b  = ui_new[2*n+1];
         ao = ui_old[2*n];
         case (act[3*n +: 3])
            3'd0:    r[n] = a & b;
            3'd1:    r[n] = a | b;
            3'd2:    r[n] = a ^ b;
            3'd3:    r[n] = ~(a & b);
            3'd4:    r[n] = ~(a | b);
            3'd5:    r[n] = ~(a ^ b);
            3'd6:    r[n] = a;
            default: r[n] = res_old[n] ^ (a & ~ao & b);
         endcase
      end
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_smp(input int kind, input string nm, input logic [7:0] val);
      kind_q.push_back(kind);
      name_q.push_back(nm);
      val_q.push_back(val);
   endtask

   task automatic apply_ui(input logic [7:0] v);
      logic [3:0] nr;
      nr = model_res(m_act, v, m_ui, m_res);
      if (nr != m_res) ev_q.push_back({nr ^ m_res, nr});
      bus.ui_in = v;
      m_ui      = v;
      m_res     = nr;
      tick(8);
      expect_smp(0, "result", {4'h0, nr});
      expect_smp(4, "absent_channels", 8'h00);
   endtask

   task automatic strobe(input logic d, input logic sh, input logic la);
      logic [11:0] old_sr;
      logic [3:0]  nr;
      old_sr        = m_sr;
      bus.uio_in[0] = d;
      tick(2);
      if (la) begin
         nr = model_res(old_sr, m_ui, m_ui, m_res);
         if (nr != m_res) ev_q.push_back({nr ^ m_res, nr});
         m_res = nr;
         m_act = old_sr;
      end
      if (sh) m_sr = {old_sr[10:0], d};
      bus.uio_in[1] = sh;
      bus.uio_in[2] = la;
      tick(4);
      bus.uio_in[2:1] = 2'b00;
      tick(3);
      expect_smp(1, "readback", {m_sr[11], 7'h00});
   endtask

   task automatic load_word(input logic [11:0] w);
      for (int i = 11; i >= 0; i--) strobe(w[i], 1'b1, 1'b0);
   endtask

   logic [7:0] toggle_exp[3];

   initial begin
      toggle_exp = '{8'h01, 8'h00, 8'h01};
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      bus.ena    = 1'b1;
      m_ui = 8'h00; m_sr = '0; m_act = '0; m_res = '0;

      // reset values, then first result timing with ui_in = 0x03
      tick(2);
      expect_smp(0, "rst_uo_out", 8'h00);
      expect_smp(1, "rst_uio_out", 8'h00);
      expect_smp(2, "uio_oe", 8'h80);
      tick(1);
      rst_n     = 1'b1;
      bus.ui_in = 8'h03;
      m_ui      = 8'h03;
      tick(4);
      expect_smp(0, "startup_edge4", 8'h00);
      ev_q.push_back(8'h11);
      m_res = 4'h1;
      tick(1);
      expect_smp(0, "startup_edge5", 8'h11);
      expect_smp(3, "one_chan_edge5", 8'h11);
      tick(1);
      expect_smp(0, "startup_edge6", 8'h01);
      expect_smp(3, "one_chan_edge6", 8'h01);

      // glitch rejection and acceptance
      bus.ui_in = 8'h01;
      tick(1);
      bus.ui_in = 8'h03;
      tick(8);
      expect_smp(0, "glitch_1cyc", 8'h01);
      ev_q.push_back(8'h10);
      ev_q.push_back(8'h11);
      bus.ui_in = 8'h01;
      tick(2);
      bus.ui_in = 8'h03;
      tick(10);
      expect_smp(0, "glitch_2cyc", 8'h01);

      // {PASS, XNOR, OR, XOR}
      load_word(12'hD4A);
      strobe(1'b0, 1'b0, 1'b1);
      apply_ui(8'h5A);
      expect_smp(0, "cfg_5a", 8'h0B);
      for (int i = 0; i < 256; i++) apply_ui(8'(i));

      // ch0 TOGGLE, others AND
      apply_ui(8'h00);
      load_word(12'h007);
      strobe(1'b0, 1'b0, 1'b1);
      apply_ui(8'h02);
      for (int i = 0; i < 3; i++) begin
         apply_ui(8'h03);
         expect_smp(0, "toggle_rise", toggle_exp[i]);
         apply_ui(8'h02);
      end
      apply_ui(8'h00);
      apply_ui(8'h01);
      apply_ui(8'h00);
      apply_ui(8'h01);
      expect_smp(0, "toggle_b0_hold", 8'h01);

      // simultaneous shift+latch: all-OR latched, all-XOR left in shift_reg
      load_word(12'h249);
      strobe(1'b0, 1'b1, 1'b1);
      apply_ui(8'h03);
      expect_smp(0, "simul_pre_shift", 8'h01);
      strobe(1'b0, 1'b0, 1'b1);
      apply_ui(8'h01);
      expect_smp(0, "simul_post_latch", 8'h01);

      // reset in the middle of a shift sequence
      strobe(1'b1, 1'b1, 1'b0);
      strobe(1'b0, 1'b1, 1'b0);
      strobe(1'b1, 1'b1, 1'b0);
      strobe(1'b1, 1'b1, 1'b0);
      strobe(1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      m_sr = '0; m_act = '0; m_res = '0;
      expect_smp(0, "midrst_uo_out", 8'h00);
      expect_smp(1, "midrst_uio_out", 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(6);
      apply_ui(8'h0F);
      expect_smp(0, "post_rst_and", 8'h03);
      // {NOR, NAND, AND, XNOR}
      load_word(12'h8C5);
      strobe(1'b0, 1'b0, 1'b1);
      apply_ui(8'h5A);
      expect_smp(0, "post_rst_cfg_5a", 8'h04);
      apply_ui(8'hA5);
      apply_ui(8'h3C);
      apply_ui(8'hFF);
      apply_ui(8'h00);

      tick(4);
      finish_req = 1'b1;
      repeat (3) @(posedge clk);
      if (!mon_done) $display("FAIL monitor_done got=0 want=1");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + (mon_done ? 0 : 1));
      $finish;
   end

endmodule
